vec_inst_queue: RTL and testbench

Instruction queue between the scalar processor's issue port and `vec_decode`. Each cycle it accepts at most one instruction with its scalar operands, keeps only vector instructions in a circular FIFO, and presents the oldest entry to `vec_decode` through a valid/ready handshake. Non-vector instructions are consumed and dropped. The block also tracks whether any queued entry is a vector-configuration instruction, so the scalar side can stall reads of `vl`/`vtype`.

---
 rtl/vec_inst_queue.sv | 153 +++++++++++++++
 tb/tb_vec_inst_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vec_inst_queue.sv
// vec_inst_queue: instruction queue between the scalar issue port and vec_decode.
// Accepts at most one instruction per cycle, keeps only vector instructions
// (opcodes 7'h57 and 7'h07) in a circular FIFO, and drops everything else.
// Tracks whether any queued entry is a vsetvli/vsetivli/vsetvl so the scalar
// side can stall vl/vtype reads.
//
// Optional feature: define VEC_QUEUE_BYPASS_EN to let a vector instruction
// pass combinationally to the outputs when the queue is empty and vec_decode
// is ready (nothing is stored in that case).
//
// Ports:
//   clk, reset                    clock, async active-high reset
//   inst_valid_i / inst_ready_o   scalar-side offer / accept (ready = !full)
//   inst_i, rs1_i, rs2_i          instruction word and captured scalar operands
//   flush_i                       discard all entries (highest priority)
//   vec_valid_o / vec_ready_i     head-entry handshake toward vec_decode
//   vec_inst_o, rs1_o, rs2_o      head-entry fields, zero when empty
//   count_o                       number of occupied entries
//   cfg_pending_o                 a config instruction is queued
module vec_inst_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       inst_valid_i,
    output logic                       inst_ready_o,
    input  logic [XLEN-1:0]            inst_i,
    input  logic [XLEN-1:0]            rs1_i,
    input  logic [XLEN-1:0]            rs2_i,
    input  logic                       flush_i,
    output logic                       vec_valid_o,
    input  logic                       vec_ready_i,
    output logic [XLEN-1:0]            vec_inst_o,
    output logic [XLEN-1:0]            rs1_o,
    output logic [XLEN-1:0]            rs2_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       cfg_pending_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [6:0] OP_VARITH = 7'h57;
    localparam logic [6:0] OP_VLOAD  = 7'h07;
    localparam logic [2:0] F3_CFG    = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   cfg_cnt;

    logic            empty;
    logic            full;
    logic            in_is_vec;
    logic            in_is_cfg;
    logic            head_is_cfg;
    logic            enq_fire;
    logic            bypass;
    logic            wr_en;
    logic            deq_fire;
    logic            cfg_inc;
    logic            cfg_dec;
    entry_t          head;

    // Occupancy from the extra-MSB pointer scheme
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Instruction classification
    assign in_is_vec = (inst_i[6:0] == OP_VARITH) || (inst_i[6:0] == OP_VLOAD);
    assign in_is_cfg = (inst_i[6:0] == OP_VARITH) && (inst_i[14:12] == F3_CFG);

    assign head        = mem[rd_ptr[AW-1:0]];
    assign head_is_cfg = (head.inst[6:0] == OP_VARITH) && (head.inst[14:12] == F3_CFG);

    // Ready depends on registers and reset only; held low while in reset
    assign inst_ready_o = !full && !reset;
    assign enq_fire     = inst_valid_i && inst_ready_o && !flush_i;

`ifdef VEC_QUEUE_BYPASS_EN
    // Empty queue and ready consumer: hand the instruction straight through
    assign bypass = enq_fire && in_is_vec && empty && vec_ready_i;
`else
    assign bypass = 1'b0;
`endif

    assign wr_en    = enq_fire && in_is_vec && !bypass;
    assign deq_fire = !empty && vec_ready_i && !flush_i;
    assign cfg_inc  = wr_en && in_is_cfg;
    assign cfg_dec  = deq_fire && head_is_cfg;

    // Head presentation, zeroed when there is nothing to show
    always_comb begin
        vec_valid_o = 1'b0;
        vec_inst_o  = '0;
        rs1_o       = '0;
        rs2_o       = '0;
        if (!empty) begin
            vec_valid_o = 1'b1;
            vec_inst_o  = head.inst;
            rs1_o       = head.rs1;
            rs2_o       = head.rs2;
        end else if (bypass) begin
            vec_valid_o = 1'b1;
            vec_inst_o  = inst_i;
            rs1_o       = rs1_i;
            rs2_o       = rs2_i;
        end
    end

    assign count_o       = wr_ptr - rd_ptr;
    assign cfg_pending_o = (cfg_cnt != '0);

    // Pointer and config-counter state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cfg_cnt <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cfg_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (cfg_inc && !cfg_dec) begin
                cfg_cnt <= cfg_cnt + PW'(1);
            end else if (cfg_dec && !cfg_inc) begin
                cfg_cnt <= cfg_cnt - PW'(1);
            end
        end
    end

    // Entry storage; contents are qualified by the pointers so no reset needed
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= '{inst: inst_i, rs1: rs1_i, rs2: rs2_i};
        end
    end

endmodule

// File: tb/tb_vec_inst_queue.sv
module tb_vec_inst_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    localparam logic [31:0] VADD = 32'h0201_0057;
    localparam logic [31:0] ADDI = 32'h0010_0093;
    localparam logic [31:0] VSET = 32'h00D0_7557;
    localparam logic [31:0] VLD1 = 32'h0010_0007;
    localparam logic [31:0] VLD2 = 32'h0020_0007;
    localparam logic [31:0] VLD3 = 32'h0030_0007;
    localparam logic [31:0] VLD4 = 32'h0040_0007;
    localparam logic [31:0] VLD5 = 32'h0050_0007;

    logic            clk = 1'b0;
    logic            reset;
    logic            inst_valid_i;
    logic            inst_ready_o;
    logic [XLEN-1:0] inst_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            vec_valid_o;
    logic            vec_ready_i;
    logic [XLEN-1:0] vec_inst_o;
    logic [XLEN-1:0] rs1_o;
    logic [XLEN-1:0] rs2_o;
    logic [CW-1:0]   count_o;
    logic            cfg_pending_o;

    int checks = 0;
    int errors = 0;

    vec_inst_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_valid_i (inst_valid_i),
        .inst_ready_o (inst_ready_o),
        .inst_i       (inst_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .flush_i      (flush_i),
        .vec_valid_o  (vec_valid_o),
        .vec_ready_i  (vec_ready_i),
        .vec_inst_o   (vec_inst_o),
        .rs1_o        (rs1_o),
        .rs2_o        (rs2_o),
        .count_o      (count_o),
        .cfg_pending_o(cfg_pending_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        vr;
        logic        fl;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        int          e_cnt;
        logic        e_cfg;
    } vec_t;

    vec_t vecs [26];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] inst, input logic [31:0] r1,
                         input logic [31:0] r2, input logic vr, input logic fl);
        inst_valid_i = iv;
        inst_i       = inst;
        rs1_i        = r1;
        rs2_i        = r2;
        vec_ready_i  = vr;
        flush_i      = fl;
    endtask

    function automatic vec_t mk(input logic iv, input logic [31:0] inst, input logic [31:0] r1,
                                input logic [31:0] r2, input logic vr, input logic fl,
                                input logic er, input logic ev, input logic [31:0] ei,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input int ec, input logic ecfg);
        vec_t v;
        v.iv = iv; v.inst = inst; v.rs1 = r1; v.rs2 = r2; v.vr = vr; v.fl = fl;
        v.e_ready = er; v.e_valid = ev; v.e_inst = ei; v.e_rs1 = e1; v.e_rs2 = e2;
        v.e_cnt = ec; v.e_cfg = ecfg;
        return v;
    endfunction

    initial begin
        // iv inst r1 r2 vr fl | ready valid inst rs1 rs2 cnt cfg (state after the edge)
        vecs[0]  = mk(1, VADD, 5,  7,  0, 0,  1, 1, VADD, 5,  7,  1, 0);
        vecs[1]  = mk(0, 0,    0,  0,  1, 0,  1, 0, 0,    0,  0,  0, 0);
        vecs[2]  = mk(1, ADDI, 9,  9,  0, 0,  1, 0, 0,    0,  0,  0, 0);
        vecs[3]  = mk(1, VLD1, 1,  17, 0, 0,  1, 1, VLD1, 1,  17, 1, 0);
        vecs[4]  = mk(1, VLD2, 2,  18, 0, 0,  1, 1, VLD1, 1,  17, 2, 0);
        vecs[5]  = mk(1, VLD3, 3,  19, 0, 0,  1, 1, VLD1, 1,  17, 3, 0);
        vecs[6]  = mk(1, VLD4, 4,  20, 0, 0,  0, 1, VLD1, 1,  17, 4, 0);
        vecs[7]  = mk(1, VLD5, 5,  21, 0, 0,  0, 1, VLD1, 1,  17, 4, 0);
        vecs[8]  = mk(1, VLD5, 5,  21, 1, 0,  1, 1, VLD2, 2,  18, 3, 0);
        vecs[9]  = mk(1, VLD5, 5,  21, 0, 0,  0, 1, VLD2, 2,  18, 4, 0);
        vecs[10] = mk(0, 0,    0,  0,  1, 0,  1, 1, VLD3, 3,  19, 3, 0);
        vecs[11] = mk(0, 0,    0,  0,  1, 0,  1, 1, VLD4, 4,  20, 2, 0);
        vecs[12] = mk(0, 0,    0,  0,  1, 0,  1, 1, VLD5, 5,  21, 1, 0);
        vecs[13] = mk(0, 0,    0,  0,  1, 0,  1, 0, 0,    0,  0,  0, 0);
        vecs[14] = mk(1, VSET, 10, 11, 0, 0,  1, 1, VSET, 10, 11, 1, 1);
        vecs[15] = mk(1, VADD, 12, 13, 0, 0,  1, 1, VSET, 10, 11, 2, 1);
        vecs[16] = mk(0, 0,    0,  0,  1, 0,  1, 1, VADD, 12, 13, 1, 0);
        vecs[17] = mk(0, 0,    0,  0,  0, 0,  1, 1, VADD, 12, 13, 1, 0);
        vecs[18] = mk(1, VSET, 20, 21, 1, 0,  1, 1, VSET, 20, 21, 1, 1);
        vecs[19] = mk(1, VLD1, 1,  17, 0, 0,  1, 1, VSET, 20, 21, 2, 1);
        vecs[20] = mk(1, VADD, 30, 31, 0, 0,  1, 1, VSET, 20, 21, 3, 1);
        vecs[21] = mk(1, VSET, 40, 41, 1, 1,  1, 0, 0,    0,  0,  0, 0);
        vecs[22] = mk(0, 0,    0,  0,  0, 0,  1, 0, 0,    0,  0,  0, 0);
        vecs[23] = mk(1, VSET, 50, 52, 0, 0,  1, 1, VSET, 50, 52, 1, 1);
        vecs[24] = mk(1, VSET, 51, 53, 1, 0,  1, 1, VSET, 51, 53, 1, 1);
        vecs[25] = mk(0, 0,    0,  0,  1, 0,  1, 0, 0,    0,  0,  0, 0);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("ready_in_reset", -1, 32'(inst_ready_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("reset_ready", -1, 32'(inst_ready_o), 32'd1);
        check("reset_valid", -1, 32'(vec_valid_o), 32'd0);
        check("reset_inst",  -1, vec_inst_o, 32'd0);
        check("reset_count", -1, 32'(count_o), 32'd0);
        check("reset_cfg",   -1, 32'(cfg_pending_o), 32'd0);

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].iv, vecs[i].inst, vecs[i].rs1, vecs[i].rs2, vecs[i].vr, vecs[i].fl);
            @(posedge clk);
            #1;
            check("inst_ready", i, 32'(inst_ready_o), 32'(vecs[i].e_ready));
            check("vec_valid",  i, 32'(vec_valid_o), 32'(vecs[i].e_valid));
            check("vec_inst",   i, vec_inst_o, vecs[i].e_inst);
            check("rs1",        i, rs1_o, vecs[i].e_rs1);
            check("rs2",        i, rs2_o, vecs[i].e_rs2);
            check("count",      i, 32'(count_o), 32'(vecs[i].e_cnt));
            check("cfg_pending",i, 32'(cfg_pending_o), 32'(vecs[i].e_cfg));
        end

        // Asynchronous reset in the middle of a cycle with two entries queued
        drive(1, VADD, 1, 2, 0, 0);
        @(posedge clk);
        #1 drive(1, VSET, 3, 4, 0, 0);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0);
        check("pre_reset_count", 100, 32'(count_o), 32'd2);
        check("pre_reset_cfg",   100, 32'(cfg_pending_o), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midreset_count", 101, 32'(count_o), 32'd0);
        check("midreset_valid", 101, 32'(vec_valid_o), 32'd0);
        check("midreset_cfg",   101, 32'(cfg_pending_o), 32'd0);
        check("midreset_ready", 101, 32'(inst_ready_o), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("postreset_ready", 102, 32'(inst_ready_o), 32'd1);
        check("postreset_count", 102, 32'(count_o), 32'd0);

        // Empty queue, consumer ready, vector instruction offered
        drive(1, VADD, 8, 9, 1, 0);
        #1;
`ifdef VEC_QUEUE_BYPASS_EN
        check("byp_same_valid", 103, 32'(vec_valid_o), 32'd1);
        check("byp_same_inst",  103, vec_inst_o, VADD);
        check("byp_same_rs1",   103, rs1_o, 32'd8);
`else
        check("byp_same_valid", 103, 32'(vec_valid_o), 32'd0);
        check("byp_same_inst",  103, vec_inst_o, 32'd0);
`endif
        check("byp_same_count", 103, 32'(count_o), 32'd0);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0);
        #1;
`ifdef VEC_QUEUE_BYPASS_EN
        check("byp_next_valid", 104, 32'(vec_valid_o), 32'd0);
        check("byp_next_count", 104, 32'(count_o), 32'd0);
`else
        check("byp_next_valid", 104, 32'(vec_valid_o), 32'd1);
        check("byp_next_inst",  104, vec_inst_o, VADD);
        check("byp_next_rs2",   104, rs2_o, 32'd9);
        check("byp_next_count", 104, 32'(count_o), 32'd1);
`endif
        drive(0, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0);
        check("final_count", 105, 32'(count_o), 32'd0);
        check("final_valid", 105, 32'(vec_valid_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
